// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared character codes for decoder, scan controller and converter
//
// Purpose : one definition of the 6-bit character code space so the Morse
//           decoder, the display scan controller and the seven-segment
//           converter cannot drift apart.
// Contents: CODE_W, BLANK_CODE, char_code_e (A..Z, 0..9, punctuation),
//           is_blank() helper.
package display_pkg;

    localparam int CODE_W = 6;

    // Rendered all-off by the converter; also fills empty buffer entries.
    localparam logic [CODE_W-1:0] BLANK_CODE = 6'h3F;

    typedef enum logic [CODE_W-1:0] {
        CH_A = 6'h00, CH_B = 6'h01, CH_C = 6'h02, CH_D = 6'h03,
        CH_E = 6'h04, CH_F = 6'h05, CH_G = 6'h06, CH_H = 6'h07,
        CH_I = 6'h08, CH_J = 6'h09, CH_K = 6'h0A, CH_L = 6'h0B,
        CH_M = 6'h0C, CH_N = 6'h0D, CH_O = 6'h0E, CH_P = 6'h0F,
        CH_Q = 6'h10, CH_R = 6'h11, CH_S = 6'h12, CH_T = 6'h13,
        CH_U = 6'h14, CH_V = 6'h15, CH_W = 6'h16, CH_X = 6'h17,
        CH_Y = 6'h18, CH_Z = 6'h19,
        CH_0 = 6'h1A, CH_1 = 6'h1B, CH_2 = 6'h1C, CH_3 = 6'h1D,
        CH_4 = 6'h1E, CH_5 = 6'h1F, CH_6 = 6'h20, CH_7 = 6'h21,
        CH_8 = 6'h22, CH_9 = 6'h23,
        CH_PERIOD   = 6'h24, CH_COMMA = 6'h25, CH_QUESTION = 6'h26,
        CH_SLASH    = 6'h27, CH_DASH  = 6'h28, CH_EQUALS   = 6'h29,
        CH_BLANK    = 6'h3F
    } char_code_e;

    function automatic logic is_blank(input logic [CODE_W-1:0] code);
        return code == BLANK_CODE;
    endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// rtl/display_scan_controller_if.sv - command and display bus of the scan controller
//
// Purpose : groups the decoder-facing strobes and the converter/board-facing
//           outputs of display_scan_controller.
// Signals : enable, letter_valid, letter_code, backspace, clear (from decoder)
//           temp_letter, onoff, anode, char_count (from scan controller)
// Modports: master - decoder / test side, drives commands
//           slave  - scan controller, drives display outputs
interface display_scan_controller_if
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 8
) ();

    logic                                  enable;
    logic                                  letter_valid;
    logic [CODE_W-1:0]                     letter_code;
    logic                                  backspace;
    logic                                  clear;
    logic [CODE_W-1:0]                     temp_letter;
    logic                                  onoff;
    logic [NUM_DIGITS-1:0]                 anode;
    logic [$clog2(NUM_DIGITS+1)-1:0]       char_count;

    modport master (
        output enable, letter_valid, letter_code, backspace, clear,
        input  temp_letter, onoff, anode, char_count
    );

    modport slave (
        input  enable, letter_valid, letter_code, backspace, clear,
        output temp_letter, onoff, anode, char_count
    );

endinterface

// File: rtl/display_scan_controller_refresh_timer.sv
// rtl/display_scan_controller_refresh_timer.sv - REFRESH_DIV down-counter with one-cycle tick
//
// Purpose : emits tick_o for one cycle every REFRESH_DIV clocks. The first
//           tick after reset lands on the REFRESH_DIV-th rising edge, the
//           same edge an up-counter running 0..REFRESH_DIV-1 would wrap on.
// Ports   : clk     - system clock
//           reset_n - asynchronous active-low reset
//           tick_o  - one-cycle pulse, high while the count sits at zero
module refresh_timer #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick_o
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == '0);

    always_comb begin
        cnt_d = tick_o ? RELOAD : cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - character buffer and digit scan for the seven-segment display
//
// Purpose : holds NUM_DIGITS character codes (entry 0 = rightmost, newest)
//           and time-multiplexes them onto the shared converter.
// Ports   : clk     - system clock
//           reset_n - asynchronous active-low reset
//           bus     - slave side of display_scan_controller_if:
//                     enable/letter_valid/letter_code/backspace/clear in,
//                     temp_letter/onoff/anode/char_count out
module display_scan_controller
    import display_pkg::*;
#(
    parameter int                NUM_DIGITS  = 8,
    parameter int                REFRESH_DIV = 100000,
    parameter logic [CODE_W-1:0] BLANK_CODE  = display_pkg::BLANK_CODE
) (
    input  logic                         clk,
    input  logic                         reset_n,
    display_scan_controller_if.slave     bus
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(NUM_DIGITS + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_DIGITS);

    logic [CODE_W-1:0]     buf_q [NUM_DIGITS];
    logic [CODE_W-1:0]     buf_d [NUM_DIGITS];
    logic [CNT_W-1:0]      count_q, count_d;
    logic [IDX_W-1:0]      scan_idx_q, scan_idx_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic                  onoff_q;
    logic                  tick;

    refresh_timer #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_refresh_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .tick_o  (tick)
    );

    // Strobe priority clear > backspace > letter_valid; losers are dropped.
    always_comb begin
        buf_d   = buf_q;
        count_d = count_q;
        if (bus.clear) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                buf_d[i] = BLANK_CODE;
            end
            count_d = '0;
        end else if (bus.backspace) begin
            // An empty buffer is already all blank, so nothing moves.
            if (count_q != '0) begin
                for (int i = 0; i < NUM_DIGITS - 1; i++) begin
                    buf_d[i] = buf_q[i+1];
                end
                buf_d[NUM_DIGITS-1] = BLANK_CODE;
                count_d = count_q - CNT_W'(1);
            end
        end else if (bus.letter_valid) begin
            for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                buf_d[i] = buf_q[i-1];
            end
            buf_d[0] = bus.letter_code;
            if (count_q != FULL) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // NUM_DIGITS is a power of two, so the increment wraps by itself.
    always_comb begin
        scan_idx_d = tick ? scan_idx_q + IDX_W'(1) : scan_idx_q;
    end

    // Built from the current scan_idx so the anode trails it by one cycle,
    // lining up with the converter's registered segment output.
    always_comb begin
        anode_d = bus.enable ? ~(NUM_DIGITS'(1) << scan_idx_q) : '1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                buf_q[i] <= BLANK_CODE;
            end
            count_q    <= '0;
            scan_idx_q <= '0;
            anode_q    <= '1;
            onoff_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                buf_q[i] <= buf_d[i];
            end
            count_q    <= count_d;
            scan_idx_q <= scan_idx_d;
            anode_q    <= anode_d;
            onoff_q    <= bus.enable;
        end
    end

    assign bus.temp_letter = buf_q[scan_idx_q];
    assign bus.onoff       = onoff_q;
    assign bus.anode       = anode_q;
    assign bus.char_count  = count_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - self-checking bench for display_scan_controller
module tb_display_scan_controller;
    import display_pkg::*;

    localparam int ND = 8;
    localparam int RD = 4;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    display_scan_controller_if #(.NUM_DIGITS(ND)) bus();

    display_scan_controller #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CODE  (6'h3F)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model written from the behavioural description.
    logic [5:0] m_buf [ND];
    int         m_cnt, m_idx, m_count;
    logic [7:0] m_anode;
    logic       m_onoff;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            foreach (m_buf[i]) m_buf[i] = 6'h3F;
            m_cnt = 0; m_idx = 0; m_count = 0;
            m_anode = 8'hFF; m_onoff = 1'b0;
        end else begin
            m_anode = bus.enable ? ~(8'h01 << m_idx) : 8'hFF;
            m_onoff = bus.enable;
            if (bus.clear) begin
                foreach (m_buf[i]) m_buf[i] = 6'h3F;
                m_count = 0;
            end else if (bus.backspace) begin
                if (m_count > 0) begin
                    for (int i = 0; i < ND - 1; i++) m_buf[i] = m_buf[i+1];
                    m_buf[ND-1] = 6'h3F;
                    m_count--;
                end
            end else if (bus.letter_valid) begin
                for (int i = ND - 1; i > 0; i--) m_buf[i] = m_buf[i-1];
                m_buf[0] = bus.letter_code;
                if (m_count < ND) m_count++;
            end
            if (m_cnt == RD - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % ND;
            end else begin
                m_cnt++;
            end
        end
    end

    bit mon_on = 1'b0;

    always @(negedge clk) begin
        if (mon_on && reset_n) begin
            chk("mon_anode", {24'h0, bus.anode}, {24'h0, m_anode});
            chk("mon_onoff", {31'h0, bus.onoff}, {31'h0, m_onoff});
            chk("mon_temp",  {26'h0, bus.temp_letter}, {26'h0, m_buf[m_idx]});
            chk("mon_count", {28'h0, bus.char_count}, m_count);
        end
    end

    typedef struct {
        string      tag;
        int         digit;
        logic [5:0] code;
    } exp_t;

    exp_t sb[$];

    task automatic expect_digit(input string tag, input int d, input logic [5:0] c);
        exp_t e;
        e.tag = tag; e.digit = d; e.code = c;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t       e;
        int         t;
        logic [7:0] a_exp;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            t = 0;
            @(negedge clk);
            while (m_idx != e.digit && t < 64) begin
                @(negedge clk);
                t++;
            end
            if (m_idx != e.digit) begin
                chk({e.tag, "_timeout"}, m_idx, e.digit);
            end else begin
                chk({e.tag, "_code"}, {26'h0, bus.temp_letter}, {26'h0, e.code});
                @(negedge clk);
                a_exp = ~(8'h01 << e.digit);
                chk({e.tag, "_anode"}, {24'h0, bus.anode}, {24'h0, a_exp});
            end
        end
    endtask

    task automatic strobe(input bit lv, input logic [5:0] code, input bit bs, input bit clr);
        bus.letter_valid = lv;
        bus.letter_code  = code;
        bus.backspace    = bs;
        bus.clear        = clr;
        @(negedge clk);
        bus.letter_valid = 1'b0;
        bus.backspace    = 1'b0;
        bus.clear        = 1'b0;
    endtask

    logic [7:0] a_hold;

    initial begin
        bus.enable       = 1'b1;
        bus.letter_valid = 1'b0;
        bus.letter_code  = 6'h00;
        bus.backspace    = 1'b0;
        bus.clear        = 1'b0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_anode", {24'h0, bus.anode}, 32'hFF);
        chk("rst_onoff", {31'h0, bus.onoff}, 32'h0);
        chk("rst_temp",  {26'h0, bus.temp_letter}, 32'h3F);
        chk("rst_count", {28'h0, bus.char_count}, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("first_anode", {24'h0, bus.anode}, 32'hFE);
        mon_on = 1'b1;
        expect_digit("wrap7", 7, 6'h3F);
        expect_digit("wrap0", 0, 6'h3F);
        drain();

        strobe(1, 6'h00, 0, 0);
        strobe(1, 6'h01, 0, 0);
        strobe(1, 6'h02, 0, 0);
        chk("append_count", {28'h0, bus.char_count}, 32'd3);
        expect_digit("app_e2", 2, 6'h00);
        expect_digit("app_e1", 1, 6'h01);
        expect_digit("app_e0", 0, 6'h02);
        drain();

        strobe(0, 6'h00, 0, 1);
        for (int i = 0; i < 9; i++) strobe(1, 6'(6'h10 + i), 0, 0);
        chk("ovf_count", {28'h0, bus.char_count}, 32'd8);
        expect_digit("ovf_e7", 7, 6'h11);
        expect_digit("ovf_e0", 0, 6'h18);
        expect_digit("ovf_e6", 6, 6'h12);
        drain();

        strobe(0, 6'h00, 0, 1);
        strobe(1, 6'h00, 0, 0);
        strobe(1, 6'h01, 0, 0);
        strobe(1, 6'h02, 0, 0);
        strobe(0, 6'h00, 1, 0);
        strobe(0, 6'h00, 1, 0);
        chk("bs2_count", {28'h0, bus.char_count}, 32'd1);
        expect_digit("bs2_e0", 0, 6'h00);
        expect_digit("bs2_e1", 1, 6'h3F);
        drain();
        strobe(0, 6'h00, 1, 0);
        strobe(0, 6'h00, 1, 0);
        chk("bs4_count", {28'h0, bus.char_count}, 32'd0);
        expect_digit("bs4_e0", 0, 6'h3F);
        expect_digit("bs4_e7", 7, 6'h3F);
        drain();

        strobe(1, 6'h03, 0, 0);
        strobe(1, 6'h05, 0, 1);
        chk("clr_lv_count", {28'h0, bus.char_count}, 32'd0);
        expect_digit("clr_lv_e0", 0, 6'h3F);
        drain();
        strobe(1, 6'h07, 0, 0);
        strobe(1, 6'h08, 0, 0);
        strobe(1, 6'h05, 1, 0);
        chk("bs_lv_count", {28'h0, bus.char_count}, 32'd1);
        expect_digit("bs_lv_e0", 0, 6'h07);
        expect_digit("bs_lv_e1", 1, 6'h3F);
        drain();

        strobe(1, 6'h3F, 0, 0);
        chk("blank_code_count", {28'h0, bus.char_count}, 32'd2);

        repeat (2) @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
        chk("dis_onoff", {31'h0, bus.onoff}, 32'h0);
        chk("dis_anode", {24'h0, bus.anode}, 32'hFF);
        repeat (9) @(negedge clk);
        a_hold = ~(8'h01 << m_idx);
        bus.enable = 1'b1;
        @(negedge clk);
        chk("ren_onoff", {31'h0, bus.onoff}, 32'h1);
        chk("ren_anode", {24'h0, bus.anode}, {24'h0, a_hold});

        strobe(1, 6'h2A, 0, 0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_anode", {24'h0, bus.anode}, 32'hFF);
        chk("async_onoff", {31'h0, bus.onoff}, 32'h0);
        chk("async_temp",  {26'h0, bus.temp_letter}, 32'h3F);
        chk("async_count", {28'h0, bus.char_count}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_anode", {24'h0, bus.anode}, 32'hFE);
        expect_digit("post_rst_e0", 0, 6'h3F);
        drain();

        mon_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
